// File: rtl/turbo_encoder_ctrl.sv
// Sequencer for a two-constituent turbo encoder: clear, K data steps, then a
// three-step tail on each encoder. Handshakes one symbol per cycle with out_ready.
module turbo_encoder_ctrl #(
  parameter int unsigned K  = 40,
  parameter int unsigned IW = 6
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_out_ready,
  output logic          o_enc_clr,
  output logic          o_enc1_en,
  output logic          o_enc2_en,
  output logic          o_term_en,
  output logic [IW-1:0] o_bit_idx,
  output logic          o_out_valid,
  output logic          o_busy,
  output logic          o_done
);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StEncode,
    StTerm1,
    StTerm2,
    StFin
  } state_t;

  localparam logic [IW-1:0] LastData = IW'(K - 1);
  localparam logic [IW-1:0] LastTail = IW'(2);

  state_t        r_state;
  logic [IW-1:0] r_bit_idx;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= StIdle;
      r_bit_idx <= '0;
    end else if (i_abort) begin
      // Abort wins over start, handshakes and phase ends alike.
      r_state   <= StIdle;
      r_bit_idx <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_bit_idx <= '0;
          if (i_start) r_state <= StClear;
        end
        StClear: begin
          r_bit_idx <= '0;
          r_state   <= StEncode;
        end
        StEncode: begin
          if (i_out_ready) begin
            if (r_bit_idx == LastData) begin
              r_state   <= StTerm1;
              r_bit_idx <= '0;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
        StTerm1: begin
          if (i_out_ready) begin
            if (r_bit_idx == LastTail) begin
              r_state   <= StTerm2;
              r_bit_idx <= '0;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
        StTerm2: begin
          if (i_out_ready) begin
            if (r_bit_idx == LastTail) begin
              r_state   <= StFin;
              r_bit_idx <= '0;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
        StFin: begin
          r_state   <= StIdle;
          r_bit_idx <= '0;
        end
        default: begin
          r_state   <= StIdle;
          r_bit_idx <= '0;
        end
      endcase
    end
  end

  logic w_encode;
  logic w_term1;
  logic w_term2;

  assign w_encode = (r_state == StEncode);
  assign w_term1  = (r_state == StTerm1);
  assign w_term2  = (r_state == StTerm2);

  // Enables follow out_ready in the same cycle so a stalled symbol is never shifted.
  assign o_enc_clr   = (r_state == StClear);
  assign o_enc1_en   = (w_encode | w_term1) & i_out_ready;
  assign o_enc2_en   = (w_encode | w_term2) & i_out_ready;
  assign o_term_en   = w_term1 | w_term2;
  assign o_out_valid = (w_encode | w_term1 | w_term2) & i_out_ready;
  assign o_bit_idx   = r_bit_idx;
  assign o_busy      = (r_state != StIdle);
  assign o_done      = (r_state == StFin);

endmodule
